// File: rtl/lsu_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_access_ctrl
// Purpose  : Load/store access controller in front of the data memory.
//            Forms the effective address (base + sign-extended offset),
//            screens it for alignment and range, runs a req/ack transaction
//            to data memory and hands the result to register writeback.
//
// Ports    : clk, reset            - clock (rising edge), sync active-high reset
//            in_valid, inopcode    - execute-stage op (100011 load, 101011 store)
//            indataout1            - base register value
//            inextendout           - sign-extended offset
//            indataout2            - store data
//            inrd                  - load destination register
//            stall                 - hold upstream pipeline (combinational)
//            mem_req/we/addr/wdata - memory request, held until acknowledged
//            mem_ack, mem_rdata    - memory completion and load data
//            out_valid             - one-cycle completion pulse
//            memout                - last successful load result
//            outrd, wb_en          - writeback register and write enable
//            fault                 - misaligned, out-of-range or timeout
//
// Revision : 1.0 - initial release
// ============================================================================
module lsu_access_ctrl #(
    parameter int MEM_DEPTH = 65,
    parameter int ADDR_W    = 7,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [5:0]        inopcode,
    input  logic [31:0]       indataout1,
    input  logic [31:0]       inextendout,
    input  logic [31:0]       indataout2,
    input  logic [4:0]        inrd,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic [31:0]       memout,
    output logic [4:0]        outrd,
    output logic              wb_en,
    output logic              fault
);

    localparam logic [5:0]  c_OP_LOAD  = 6'b100011;
    localparam logic [5:0]  c_OP_STORE = 6'b101011;
    localparam logic [29:0] c_DEPTH    = 30'(MEM_DEPTH);
    localparam int          c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [4:0]          r_rd;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_out_valid;
    logic [31:0]         r_memout;
    logic [4:0]          r_outrd;
    logic                r_wb_en;
    logic                r_fault;

    logic [31:0]         w_ea;
    logic                w_is_ldst;
    logic                w_accept;
    logic                w_bad;

    assign w_ea      = indataout1 + inextendout;
    assign w_is_ldst = (inopcode == c_OP_LOAD) || (inopcode == c_OP_STORE);
    assign w_accept  = (r_state == S_IDLE) && in_valid && w_is_ldst;
    // Bad addresses never reach memory; they complete straight through DONE.
    assign w_bad     = (w_ea[1:0] != 2'b00) || (w_ea[31:2] >= c_DEPTH);

    // Stall covers the accepting cycle too so the op is held until latched.
    assign stall     = (r_state == S_REQ) || (r_state == S_WAIT) || w_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_out_valid <= 1'b0;
            r_memout    <= '0;
            r_outrd     <= '0;
            r_wb_en     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mem_we    <= (inopcode == c_OP_STORE);
                        r_mem_addr  <= w_ea[ADDR_W+1:2];
                        r_mem_wdata <= indataout2;
                        r_rd        <= inrd;
                        if (w_bad) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_fault     <= 1'b1;
                            r_wb_en     <= 1'b0;
                            r_outrd     <= inrd;
                        end else begin
                            r_state   <= S_REQ;
                            r_mem_req <= 1'b1;
                        end
                    end
                end

                S_REQ, S_WAIT: begin
                    if (mem_ack) begin
                        r_state     <= S_DONE;
                        r_mem_req   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_fault     <= 1'b0;
                        r_wb_en     <= ~r_mem_we;
                        r_outrd     <= r_rd;
                        if (!r_mem_we) begin
                            r_memout <= mem_rdata;
                        end
                    end else if (r_state == S_REQ) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        // Ack is checked first, so the last WAIT cycle can still succeed.
                        r_state     <= S_DONE;
                        r_mem_req   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_fault     <= 1'b1;
                        r_wb_en     <= 1'b0;
                        r_outrd     <= r_rd;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_DONE: begin
                    r_out_valid <= 1'b0;
                    r_fault     <= 1'b0;
                    r_wb_en     <= 1'b0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign out_valid = r_out_valid;
    assign memout    = r_memout;
    assign outrd     = r_outrd;
    assign wb_en     = r_wb_en;
    assign fault     = r_fault;

endmodule
`default_nettype wire

// File: doc/lsu_access_ctrl.md
Name: lsu_access_ctrl

Overview:
Load/store access controller sitting directly upstream of the data memory block. It takes decoded load/store operations from the execute stage and computes the effective address (base + sign-extended offset). It checks alignment and range, then drives a multi-cycle request/acknowledge transaction to data memory. It returns load data and a writeback strobe to the register-file writeback path and stalls the pipeline while the access is in flight.

Parameters:
MEM_DEPTH, 65, number of 32-bit words in data memory (valid word indices 0..MEM_DEPTH-1)
ADDR_W, 7, width of mem_addr word index
TIMEOUT, 15, maximum cycles in WAIT without mem_ack before a fault is raised

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  execute stage presents an instruction this cycle
inopcode  input  6  opcode from decoder; 6'b100011 = load, 6'b101011 = store
indataout1  input  32  base register value from register block
inextendout  input  32  sign-extended offset from sign-extend block
indataout2  input  32  store data from register block
inrd  input  5  load destination register
stall  output  1  hold upstream pipeline
mem_req  output  1  memory request, held until acknowledged
mem_we  output  1  1 = store, 0 = load; valid while mem_req
mem_addr  output  ADDR_W  word index to memory
mem_wdata  output  32  store data
mem_ack  input  1  memory completed request this cycle
mem_rdata  input  32  load data, valid with mem_ack
out_valid  output  1  one-cycle completion pulse
memout  output  32  load result, held until next completion
outrd  output  5  destination register for writeback
wb_en  output  1  register write enable; equals out_valid for a successful load
fault  output  1  with out_valid: misaligned, out-of-range or timeout

Behaviour:
- Effective address: ea = indataout1 + inextendout, 32-bit, wrap-around ignored. Word index = ea[31:2].
- The access is misaligned if ea[1:0] != 0. It is out of range if ea[31:2] >= MEM_DEPTH.
- The FSM has four states: IDLE, REQ, WAIT and DONE. Reset puts the FSM in IDLE and clears every output to 0, including memout, outrd and the timeout counter.
- IDLE:
  - An instruction is accepted when in_valid is high and inopcode is load or store.
  - On acceptance, latch mem_we, the word index, indataout2 and inrd.
  - If the access is misaligned or out of range, go to DONE with fault latched and issue no memory request. Otherwise go to REQ.
  - Any other opcode is ignored: no stall, no state change.
- stall (combinational) = (state != IDLE && state != DONE) || (state == IDLE && in_valid && load/store opcode).
- REQ (one cycle):
  - mem_req = 1; mem_addr, mem_we and mem_wdata are driven from the latches.
  - If mem_ack, go to DONE (loads capture mem_rdata); otherwise go to WAIT and clear the counter.
- WAIT:
  - mem_req stays at 1 with stable address and data.
  - If mem_ack, go to DONE and capture data for loads.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ack, go to DONE with fault = 1 and drop mem_req.
- DONE (one cycle):
  - out_valid = 1 and outrd = latched rd.
  - wb_en = 1 only for a load without fault.
  - memout updates only for a successful load; stores and faults leave it unchanged.
  - fault is valid this cycle only. Return to IDLE.
  - stall = 0, so the next instruction may be accepted in IDLE on the following cycle.
- Minimum latency: accept at edge E0, mem_req high in cycle after E0, ack sampled at E1, out_valid high in the cycle after E1. The fault path produces out_valid in the cycle after E0.
- mem_ack outside REQ/WAIT is ignored. in_valid while busy is ignored, since upstream is stalled.
- Reset during REQ/WAIT drops mem_req in the next cycle. No out_valid or writeback is produced for the aborted access.

Test Plan:
- Load at base=8, offset=4 (word 3), memory acks in REQ with rdata=0x00000004 -> mem_addr=3, mem_we=0; out_valid and wb_en pulse 1 cycle after ack; memout=0x4; outrd=inrd; stall high for exactly 2 cycles.
- Store with base=0x20, offset=0xC (word 11), data 0xDEADBEEF, ack after 3 WAIT cycles -> mem_req held 4 cycles with stable mem_addr=11, mem_wdata=0xDEADBEEF, mem_we=1; out_valid=1, wb_en=0, memout unchanged.
- Load with ea=0x6 -> no mem_req; next cycle out_valid=1, fault=1, wb_en=0. Load with ea=0x104 (word 65) -> same fault response.
- Negative offset: base=0x30, offset=0xFFFFFFF8 -> word 10 requested.
- No ack for TIMEOUT cycles -> mem_req drops; out_valid=1, fault=1, wb_en=0; the next load completes normally.
- Reset asserted in WAIT -> mem_req=0, out_valid=0, all outputs 0 the next cycle; a later ack produces no out_valid. Non-memory opcode (6'b000000) with in_valid -> stall=0, no request.
